// File: rtl/xbus_dram_arbiter.sv
// Arbiter/sequencer for the shared xbus DRAM slave port: CPU plus two DMA
// masters (disk, chaos) serialised onto one request/ack slave interface.
module xbus_dram_arbiter #(
  parameter int unsigned TIMEOUT_BITS = 5,
  parameter int unsigned HOLD_MAX     = 16
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic        cpu_write_i,
  input  logic [21:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic        cpu_load_o,
  input  logic [1:0]  dma_busreq_i,
  output logic [1:0]  dma_grant_o,
  input  logic [1:0]  dma_req_i,
  input  logic [1:0]  dma_write_i,
  input  logic [21:0] dma0_addr_i,
  input  logic [21:0] dma1_addr_i,
  input  logic [31:0] dma0_wdata_i,
  input  logic [31:0] dma1_wdata_i,
  output logic [1:0]  dma_ack_o,
  output logic [21:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic        s_req_o,
  output logic        s_write_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_rdata_i,
  output logic [31:0] rdata_o,
  output logic        timed_out_o
);

  localparam int unsigned HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_MAX_C = HW'(HOLD_MAX);

  typedef enum logic [2:0] {IDLE, CPU_REQ, CPU_WAIT, DMA_XFER, DMA_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_was_cpu_q, last_was_cpu_d;
  logic                    last_dma_q, last_dma_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [TIMEOUT_BITS-1:0] to_cnt_q, to_cnt_d;

  logic        timeout_c;
  logic        preempt_c;
  logic        own_busreq_c;
  logic        own_req_c;
  logic        own_write_c;
  logic [21:0] own_addr_c;
  logic [31:0] own_wdata_c;

  assign timeout_c    = (state_q == CPU_REQ) && (to_cnt_q == '1);
  assign preempt_c    = cpu_req_i && (hold_cnt_q >= HOLD_MAX_C);
  assign own_busreq_c = dma_busreq_i[owner_q];
  assign own_req_c    = dma_req_i[owner_q];
  assign own_write_c  = dma_write_i[owner_q];
  assign own_addr_c   = owner_q ? dma1_addr_i  : dma0_addr_i;
  assign own_wdata_c  = owner_q ? dma1_wdata_i : dma0_wdata_i;

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_was_cpu_q <= 1'b0;
      last_dma_q     <= 1'b1;
      hold_cnt_q     <= '0;
      to_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_was_cpu_q <= last_was_cpu_d;
      last_dma_q     <= last_dma_d;
      hold_cnt_q     <= hold_cnt_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  // Next-state and slave/master muxing; every output is 0 unless selected.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_was_cpu_d = last_was_cpu_q;
    last_dma_d     = last_dma_q;
    hold_cnt_d     = hold_cnt_q;
    to_cnt_d       = '0;
    cpu_ack_o      = 1'b0;
    cpu_load_o     = 1'b0;
    dma_grant_o    = 2'b00;
    dma_ack_o      = 2'b00;
    s_addr_o       = '0;
    s_wdata_o      = '0;
    s_req_o        = 1'b0;
    s_write_o      = 1'b0;
    rdata_o        = '0;
    timed_out_o    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req_i && !(last_was_cpu_q && (|dma_busreq_i))) begin
          state_d = CPU_REQ;
        end else if (|dma_busreq_i) begin
          state_d = DMA_XFER;
          owner_d = (&dma_busreq_i) ? ~last_dma_q : dma_busreq_i[1];
        end
      end

      CPU_REQ: begin
        s_req_o     = 1'b1;
        s_write_o   = cpu_write_i;
        s_addr_o    = cpu_addr_i;
        s_wdata_o   = cpu_wdata_i;
        rdata_o     = timeout_c ? '0 : s_rdata_i;
        timed_out_o = timeout_c;
        to_cnt_d    = to_cnt_q + TIMEOUT_BITS'(1);
        if (timeout_c || s_ack_i) begin
          cpu_ack_o = 1'b1;
          to_cnt_d  = '0;
          state_d   = CPU_WAIT;
        end
      end

      CPU_WAIT: begin
        s_addr_o   = cpu_addr_i;
        s_wdata_o  = cpu_wdata_i;
        rdata_o    = s_rdata_i;
        cpu_load_o = cpu_req_i && !cpu_write_i;
        if (!cpu_req_i) begin
          state_d        = IDLE;
          last_was_cpu_d = 1'b1;
        end
      end

      DMA_XFER: begin
        dma_grant_o[owner_q] = 1'b1;
        s_req_o   = own_req_c;
        s_write_o = own_write_c;
        s_addr_o  = own_addr_c;
        s_wdata_o = own_wdata_c;
        rdata_o   = s_rdata_i;
        if (s_ack_i && own_req_c) begin
          dma_ack_o[owner_q] = 1'b1;
          if (hold_cnt_q < HOLD_MAX_C) hold_cnt_d = hold_cnt_q + HW'(1);
          state_d = DMA_WAIT;
        end else if (!own_busreq_c && !own_req_c) begin
          state_d        = IDLE;
          last_was_cpu_d = 1'b0;
          last_dma_d     = owner_q;
          hold_cnt_d     = '0;
        end
      end

      DMA_WAIT: begin
        dma_grant_o[owner_q] = 1'b1;
        s_addr_o  = own_addr_c;
        s_wdata_o = own_wdata_c;
        rdata_o   = s_rdata_i;
        // Keep the tenure unless the master lets go or a waiting CPU hit the cap.
        if (!own_req_c) begin
          if (own_busreq_c && !preempt_c) begin
            state_d = DMA_XFER;
          end else begin
            state_d        = IDLE;
            last_was_cpu_d = 1'b0;
            last_dma_d     = owner_q;
            hold_cnt_d     = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
